// File: rtl/layer_sequencer.sv
// Layer sequencer: runtime-programmable descriptor table that launches a single-layer
// engine once per layer, with step mode, graceful abort and per-layer cycle timing.
module layer_sequencer #(
  parameter  int MAX_LAYER    = 32,
  parameter  int OFM_RAM_SIZE = 2378675,
  parameter  int CYC_W        = 32,
  localparam int ADDR_W       = $clog2(OFM_RAM_SIZE),
  localparam int IDX_W        = $clog2(MAX_LAYER),
  localparam int DESC_W       = 37 + 2 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DESC_W-1:0] cfg_wdata,
  input  logic [IDX_W:0]    num_layer,
  input  logic              step_mode,
  input  logic              step_go,
  input  logic              abort,
  input  logic              start_CNN,
  output logic              done_CNN,
  output logic              aborted,
  output logic              busy,
  output logic              start_layer,
  input  logic              done_layer,
  output logic [IDX_W-1:0]  count_layer,
  output logic [8:0]        ifm_size,
  output logic [10:0]       ifm_channel,
  output logic [1:0]        kernel_size,
  output logic [10:0]       num_filter,
  output logic              maxpool_mode,
  output logic [1:0]        maxpool_stride,
  output logic              upsample_mode,
  output logic [ADDR_W-1:0] start_read_addr,
  output logic [ADDR_W-1:0] start_write_addr,
  output logic [CYC_W-1:0]  last_layer_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Engine handshake: start_layer is a single-cycle pulse in START; the engine answers
  // with a single-cycle done_layer pulse, which is honoured only while in WAIT.

  logic [DESC_W-1:0] desc_mem [MAX_LAYER];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    n_q, n_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic              abort_pend_q, abort_pend_d;
  logic              aborted_q, aborted_d;
  logic              done_cnn_q, done_cnn_d;
  logic              busy_q, busy_d;
  logic              start_layer_q, start_layer_d;
  logic [IDX_W-1:0]  count_layer_q, count_layer_d;
  logic [DESC_W-1:0] cfg_q, cfg_d;
  logic [CYC_W-1:0]  last_cyc_q, last_cyc_d;

  logic [IDX_W:0]    num_clamped;
  logic              is_last;
  logic              addr_ok;

  assign num_clamped = (num_layer > (IDX_W+1)'(MAX_LAYER)) ? (IDX_W+1)'(MAX_LAYER) : num_layer;
  assign is_last     = (({1'b0, idx_q} + (IDX_W+1)'(1)) == n_q);
  assign addr_ok     = ({1'b0, cfg_addr} < (IDX_W+1)'(MAX_LAYER));

  // The table survives rst so a host can reset the controller without reprogramming.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !busy_q && addr_ok) begin
      desc_mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    abort_pend_d  = abort_pend_q;
    aborted_d     = aborted_q;
    count_layer_d = count_layer_q;
    cfg_d         = cfg_q;
    last_cyc_d    = last_cyc_q;

    case (state_q)
      S_IDLE: begin
        if (start_CNN) begin
          n_d          = num_clamped;
          idx_d        = '0;
          cnt_d        = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (num_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cfg_d         = desc_mem[idx_q];
          count_layer_d = idx_q;
          state_d       = S_START;
        end
      end
      S_START: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_layer) begin
          last_cyc_d = (cnt_q == '1) ? cnt_q : cnt_q + CYC_W'(1);
          cnt_d      = '0;
          // An abort arriving together with done_layer still counts as an abort.
          if (abort_pend_q || abort) begin
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = S_DONE;
          end else if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = step_mode ? S_PAUSE : S_LOAD;
          end
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CYC_W'(1);
          end
          if (abort) begin
            abort_pend_d = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (step_go) begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_layer_d = (state_d == S_START);
    done_cnn_d    = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      n_q           <= '0;
      cnt_q         <= '0;
      abort_pend_q  <= 1'b0;
      aborted_q     <= 1'b0;
      done_cnn_q    <= 1'b0;
      busy_q        <= 1'b0;
      start_layer_q <= 1'b0;
      count_layer_q <= '0;
      cfg_q         <= '0;
      last_cyc_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      abort_pend_q  <= abort_pend_d;
      aborted_q     <= aborted_d;
      done_cnn_q    <= done_cnn_d;
      busy_q        <= busy_d;
      start_layer_q <= start_layer_d;
      count_layer_q <= count_layer_d;
      cfg_q         <= cfg_d;
      last_cyc_q    <= last_cyc_d;
    end
  end

  assign done_CNN          = done_cnn_q;
  assign aborted           = aborted_q;
  assign busy              = busy_q;
  assign start_layer       = start_layer_q;
  assign count_layer       = count_layer_q;
  assign last_layer_cycles = last_cyc_q;

  assign ifm_size          = cfg_q[8:0];
  assign ifm_channel       = cfg_q[19:9];
  assign kernel_size       = cfg_q[21:20];
  assign num_filter        = cfg_q[32:22];
  assign maxpool_mode      = cfg_q[33];
  assign maxpool_stride    = cfg_q[35:34];
  assign upsample_mode     = cfg_q[36];
  assign start_read_addr   = cfg_q[36+ADDR_W:37];
  assign start_write_addr  = cfg_q[DESC_W-1:37+ADDR_W];

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a reference table plus a behavioural engine that replies
// to each launch after a random delay, checking pulses, timing and config per layer.
module tb_layer_sequencer;

  localparam int MAX_LAYER    = 32;
  localparam int OFM_RAM_SIZE = 2378675;
  localparam int CYC_W        = 32;
  localparam int ADDR_W       = $clog2(OFM_RAM_SIZE);
  localparam int IDX_W        = $clog2(MAX_LAYER);
  localparam int DESC_W       = 37 + 2 * ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr_en;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DESC_W-1:0] cfg_wdata;
  logic [IDX_W:0]    num_layer;
  logic              step_mode, step_go, abort, start_CNN, done_layer;
  logic              done_CNN, aborted, busy, start_layer;
  logic [IDX_W-1:0]  count_layer;
  logic [8:0]        ifm_size;
  logic [10:0]       ifm_channel;
  logic [1:0]        kernel_size;
  logic [10:0]       num_filter;
  logic              maxpool_mode;
  logic [1:0]        maxpool_stride;
  logic              upsample_mode;
  logic [ADDR_W-1:0] start_read_addr, start_write_addr;
  logic [CYC_W-1:0]  last_layer_cycles;

  logic [DESC_W-1:0] model_tbl [MAX_LAYER];
  int err_cnt = 0;
  int chk_cnt = 0;
  int sl_cnt  = 0;
  int dc_cnt  = 0;

  layer_sequencer #(
    .MAX_LAYER(MAX_LAYER), .OFM_RAM_SIZE(OFM_RAM_SIZE), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .num_layer(num_layer), .step_mode(step_mode), .step_go(step_go), .abort(abort),
    .start_CNN(start_CNN), .done_CNN(done_CNN), .aborted(aborted), .busy(busy),
    .start_layer(start_layer), .done_layer(done_layer), .count_layer(count_layer),
    .ifm_size(ifm_size), .ifm_channel(ifm_channel), .kernel_size(kernel_size),
    .num_filter(num_filter), .maxpool_mode(maxpool_mode), .maxpool_stride(maxpool_stride),
    .upsample_mode(upsample_mode), .start_read_addr(start_read_addr),
    .start_write_addr(start_write_addr), .last_layer_cycles(last_layer_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (start_layer) sl_cnt++;
    if (done_CNN) dc_cnt++;
  end

  // ---------------- helpers ----------------
  function automatic logic [DESC_W-1:0] cfg_now();
    return {start_write_addr, start_read_addr, upsample_mode, maxpool_stride, maxpool_mode,
            num_filter, kernel_size, ifm_channel, ifm_size};
  endfunction

  function automatic logic [DESC_W-1:0] make_desc(input logic [8:0] isz, input logic [10:0] ich,
      input logic [1:0] ks, input logic [10:0] nf, input logic mpm, input logic [1:0] mps,
      input logic ups, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa);
    return {wa, ra, ups, mps, mpm, nf, ks, ich, isz};
  endfunction

  function automatic logic [DESC_W-1:0] rand_desc();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DESC_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_desc(input int i, input logic [DESC_W-1:0] v);
    cfg_wr_en = 1'b1;
    cfg_addr  = IDX_W'(i);
    cfg_wdata = v;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    model_tbl[i] = v;
  endtask

  // Runs one job and plays the engine. ab_layer < 0 means no abort; with ab_pause the
  // abort is raised in the PAUSE before ab_layer, otherwise inside ab_layer's WAIT.
  task automatic run_job(input int num, input bit step, input int ab_layer, input bit ab_pause,
                         input int hold, input bit poke, input int fix_d);
    int n_eff, exp_launch, launches, sl0, dc0, d, a, last_l;
    bit stop, exp_ab;
    n_eff = (num > MAX_LAYER) ? MAX_LAYER : num;
    if (ab_layer >= 0 && ab_layer < n_eff) exp_launch = ab_pause ? ab_layer : ab_layer + 1;
    else exp_launch = n_eff;
    sl0 = sl_cnt; dc0 = dc_cnt; launches = 0; last_l = 0; stop = 1'b0; exp_ab = 1'b0;
    step_mode = step;
    num_layer = (IDX_W+1)'(num);
    start_CNN = 1'b1;
    @(negedge clk);
    start_CNN = 1'b0;
    cfg_wr_en = 1'b0;
    chk_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    if (n_eff == 0) begin
      chk_cnt++; if (done_CNN !== 1'b1) begin err_cnt++; $display("FAIL zero_done got=%b exp=1", done_CNN); end
      stop = 1'b1;
    end else begin
      chk_cnt++; if (start_layer !== 1'b0) begin err_cnt++; $display("FAIL load_no_start got=%b exp=0", start_layer); end
    end
    for (int l = 0; l < n_eff && !stop; l++) begin
      @(negedge clk);
      launches++;
      last_l = l;
      chk_cnt++; if (start_layer !== 1'b1) begin err_cnt++; $display("FAIL start_layer L%0d got=%b exp=1", l, start_layer); end
      chk_cnt++; if (count_layer !== IDX_W'(l)) begin err_cnt++; $display("FAIL count_layer got=%0d exp=%0d", count_layer, l); end
      chk_cnt++; if (cfg_now() !== model_tbl[l]) begin err_cnt++; $display("FAIL cfg L%0d got=%h exp=%h", l, cfg_now(), model_tbl[l]); end
      d = (fix_d > 0) ? fix_d : int'($urandom_range(1, 12));
      a = (ab_layer == l && !ab_pause) ? int'($urandom_range(1, d)) : 0;
      for (int t = 1; t <= d; t++) begin
        @(negedge clk);
        abort      = (t == a);
        done_layer = (t == d);
        cfg_wr_en  = poke && (l == 0) && (t == 1);
        start_CNN  = cfg_wr_en;
        cfg_addr   = '0;
        cfg_wdata  = ~model_tbl[0];
        chk_cnt++; if (start_layer !== 1'b0) begin err_cnt++; $display("FAIL wait_no_start L%0d t%0d got=%b exp=0", l, t, start_layer); end
        chk_cnt++; if (cfg_now() !== model_tbl[l]) begin err_cnt++; $display("FAIL cfg_stable L%0d t%0d got=%h exp=%h", l, t, cfg_now(), model_tbl[l]); end
      end
      @(negedge clk);
      abort = 1'b0; done_layer = 1'b0; cfg_wr_en = 1'b0; start_CNN = 1'b0;
      chk_cnt++; if (last_layer_cycles !== CYC_W'(d)) begin err_cnt++; $display("FAIL last_cycles got=%0d exp=%0d", last_layer_cycles, d); end
      if (a != 0 || l == n_eff - 1) begin
        exp_ab = (a != 0);
        chk_cnt++; if (done_CNN !== 1'b1) begin err_cnt++; $display("FAIL done_cnn got=%b exp=1", done_CNN); end
        chk_cnt++; if (aborted !== exp_ab) begin err_cnt++; $display("FAIL aborted got=%b exp=%b", aborted, exp_ab); end
        stop = 1'b1;
      end else if (step) begin
        for (int h = 0; h < hold; h++) begin
          chk_cnt++; if (start_layer !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL pause_hold h%0d start=%b busy=%b exp start=0 busy=1", h, start_layer, busy); end
          @(negedge clk);
        end
        if (ab_pause && ab_layer == l + 1) begin
          abort = 1'b1; step_go = 1'b1;
          @(negedge clk);
          abort = 1'b0; step_go = 1'b0;
          exp_ab = 1'b1;
          chk_cnt++; if (done_CNN !== 1'b1) begin err_cnt++; $display("FAIL pause_abort_done got=%b exp=1", done_CNN); end
          chk_cnt++; if (aborted !== 1'b1) begin err_cnt++; $display("FAIL pause_abort_flag got=%b exp=1", aborted); end
          stop = 1'b1;
        end else begin
          step_go = 1'b1;
          @(negedge clk);
          step_go = 1'b0;
          chk_cnt++; if (start_layer !== 1'b0) begin err_cnt++; $display("FAIL step_load got=%b exp=0", start_layer); end
        end
      end else begin
        chk_cnt++; if (start_layer !== 1'b0) begin err_cnt++; $display("FAIL next_load got=%b exp=0", start_layer); end
      end
    end
    @(negedge clk);
    chk_cnt++; if (done_CNN !== 1'b0) begin err_cnt++; $display("FAIL done_one_cycle got=%b exp=0", done_CNN); end
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy got=%b exp=0", busy); end
    chk_cnt++; if (aborted !== exp_ab) begin err_cnt++; $display("FAIL aborted_held got=%b exp=%b", aborted, exp_ab); end
    chk_cnt++; if (sl_cnt - sl0 !== exp_launch) begin err_cnt++; $display("FAIL launch_count got=%0d exp=%0d", sl_cnt - sl0, exp_launch); end
    chk_cnt++; if (dc_cnt - dc0 !== 1) begin err_cnt++; $display("FAIL done_count got=%0d exp=1", dc_cnt - dc0); end
    if (launches > 0) begin
      chk_cnt++; if (cfg_now() !== model_tbl[last_l]) begin err_cnt++; $display("FAIL cfg_hold got=%h exp=%h", cfg_now(), model_tbl[last_l]); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({done_CNN, aborted, busy, start_layer} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags got=%b exp=0000", {done_CNN, aborted, busy, start_layer}); end
    chk_cnt++; if (count_layer !== '0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", count_layer); end
    chk_cnt++; if (cfg_now() !== '0) begin err_cnt++; $display("FAIL reset_cfg got=%h exp=0", cfg_now()); end
    chk_cnt++; if (last_layer_cycles !== '0) begin err_cnt++; $display("FAIL reset_cycles got=%0d exp=0", last_layer_cycles); end
  endtask

  task automatic test_basic();
    write_desc(0, make_desc(9'd416, 11'd3, 2'd3, 11'd16, 1'b1, 2'd2, 1'b0, '0, ADDR_W'(32'h10000)));
    write_desc(1, make_desc(9'd208, 11'd16, 2'd3, 11'd32, 1'b1, 2'd2, 1'b0, ADDR_W'(32'h10000), ADDR_W'(32'h20000)));
    write_desc(2, make_desc(9'd104, 11'd32, 2'd1, 11'd64, 1'b0, 2'd1, 1'b1, ADDR_W'(32'h20000), ADDR_W'(32'h30000)));
    run_job(3, 1'b0, -1, 1'b0, 0, 1'b0, 10);
  endtask

  task automatic test_zero();
    run_job(0, 1'b0, -1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_step();
    run_job(2, 1'b1, -1, 1'b0, 50, 1'b0, 0);
    run_job(3, 1'b1, 2, 1'b1, 5, 1'b0, 0);
  endtask

  task automatic test_abort();
    run_job(4, 1'b0, 1, 1'b0, 0, 1'b0, 0);
    run_job(2, 1'b0, 1, 1'b0, 0, 1'b0, 1);
  endtask

  task automatic test_cfg_busy();
    run_job(2, 1'b0, -1, 1'b0, 0, 1'b1, 4);
    run_job(1, 1'b0, -1, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_cfg_same_cycle();
    logic [DESC_W-1:0] v;
    v = rand_desc();
    model_tbl[0] = v;
    cfg_wr_en = 1'b1;
    cfg_addr  = '0;
    cfg_wdata = v;
    run_job(1, 1'b0, -1, 1'b0, 0, 1'b0, 2);
  endtask

  task automatic test_clamp();
    run_job(40, 1'b0, -1, 1'b0, 0, 1'b0, 2);
  endtask

  task automatic test_rst_mid();
    int sl0, dc0;
    sl0 = sl_cnt; dc0 = dc_cnt;
    step_mode = 1'b0;
    num_layer = (IDX_W+1)'(3);
    start_CNN = 1'b1;
    @(negedge clk);
    start_CNN = 1'b0;
    @(negedge clk);
    chk_cnt++; if (start_layer !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_start got=%b exp=1", start_layer); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if ({done_CNN, aborted, busy, start_layer} !== 4'b0) begin err_cnt++; $display("FAIL rst_mid_flags got=%b exp=0000", {done_CNN, aborted, busy, start_layer}); end
    chk_cnt++; if (cfg_now() !== '0 || count_layer !== '0) begin err_cnt++; $display("FAIL rst_mid_cfg got=%h/%0d exp=0/0", cfg_now(), count_layer); end
    chk_cnt++; if (last_layer_cycles !== '0) begin err_cnt++; $display("FAIL rst_mid_cycles got=%0d exp=0", last_layer_cycles); end
    @(negedge clk);
    chk_cnt++; if (sl_cnt - sl0 !== 1 || dc_cnt - dc0 !== 0) begin err_cnt++; $display("FAIL rst_mid_pulses got=%0d/%0d exp=1/0", sl_cnt - sl0, dc_cnt - dc0); end
    run_job(2, 1'b0, -1, 1'b0, 0, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    int num, ab, mode;
    bit step;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 6; i++) write_desc(i, rand_desc());
      num  = $urandom_range(1, 6);
      step = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      ab   = -1;
      if (mode == 1) ab = $urandom_range(0, num - 1);
      if (mode == 2 && step && num >= 2) ab = $urandom_range(1, num - 1);
      run_job(num, step, ab, mode == 2, $urandom_range(0, 4), 1'b0, 0);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_layer = '0;
    step_mode = 1'b0; step_go = 1'b0; abort = 1'b0; start_CNN = 1'b0; done_layer = 1'b0;
    @(negedge clk);
    test_reset();
    for (int i = 0; i < MAX_LAYER; i++) write_desc(i, rand_desc());
    test_basic();
    test_zero();
    test_step();
    test_abort();
    test_cfg_busy();
    test_cfg_same_cycle();
    test_clamp();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
